// File: rtl/imem_loader_if.sv
// imem_loader_if -- bundles the byte-stream handshake, the imem write port,
// the status outputs and a state debug tap of the instruction memory loader.
//
// Handshake: the host drives i_byte/i_valid and the loader drives o_ready.
// A byte transfers on a rising clock edge where i_valid && o_ready. o_ready
// does not depend on i_valid. While i_valid is high the host holds i_byte
// stable until the byte transfers.
//
// Modports:
//   slave  - the loader (stream sink, drives the imem write port and status)
//   master - the host/stream source (observes everything it does not drive)
//
// Signals:
//   i_start     re-arm request from DONE/ERR
//   i_byte      stream data byte, little-endian within a word
//   i_valid     i_byte is valid
//   o_ready     loader can accept a byte
//   o_we        imem write strobe, one-cycle pulse per word
//   o_waddr     imem byte address, word aligned
//   o_wdata     assembled instruction word
//   o_cpu_rst_n CPU reset, low until the load completes successfully
//   o_done      load completed successfully
//   o_error     load aborted
//   dbg_state   loader FSM state encoding, for checkers and debug
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  i_start;
  logic [7:0]            i_byte;
  logic                  i_valid;
  logic                  o_ready;
  logic                  o_we;
  logic [ADDR_WIDTH-1:0] o_waddr;
  logic [31:0]           o_wdata;
  logic                  o_cpu_rst_n;
  logic                  o_done;
  logic                  o_error;
  logic [2:0]            dbg_state;

  modport slave (
    input  i_start, i_byte, i_valid,
    output o_ready, o_we, o_waddr, o_wdata, o_cpu_rst_n, o_done, o_error,
    output dbg_state
  );

  modport master (
    output i_start, i_byte, i_valid,
    input  o_ready, o_we, o_waddr, o_wdata, o_cpu_rst_n, o_done, o_error,
    input  dbg_state
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader -- write-side counterpart of the instruction memory.
// Assembles a little-endian byte stream into 32-bit words: first a word count
// N, then N instruction words, each written to imem starting at BASE_ADDR.
// The CPU is held in reset until the whole image has been written.
//
// Optional feature (macro IMEM_LOADER_CHECKSUM_EN): after the N data words a
// 32-bit little-endian checksum follows; it must equal the sum (mod 2^32) of
// the data words, otherwise the load ends in the error state.
//
// Ports:
//   i_clk    clock, all logic on the rising edge
//   i_rst_n  synchronous active-low reset
//   bus      imem_loader_if.slave: byte stream, imem write port, status,
//            dbg_state (encoding of the state enum below)
//
// Parameters:
//   DEPTH       imem depth in words, maximum loadable word count
//   ADDR_WIDTH  width of the imem byte address
//   BASE_ADDR   byte address of the first word, 4-byte aligned
module imem_loader #(
  parameter int                    DEPTH      = 1024,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  imem_loader_if.slave bus
);

  localparam int INST_WIDTH = 32;
  // Word counter must be able to hold DEPTH itself.
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_DONE = 3'd2,
    S_ERR  = 3'd3
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    S_CSUM = 3'd4
`endif
  } state_t;

  state_t                state_q;
  logic [1:0]            idx_q;
  logic [INST_WIDTH-1:0] asm_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         n_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [INST_WIDTH-1:0] sum_q;
`endif

  logic                  byte_fire;
  logic                  last_byte;
  logic [INST_WIDTH-1:0] word_full;
  logic [CW-1:0]         count_inc;

  assign byte_fire = bus.i_valid && bus.o_ready;
  assign last_byte = byte_fire && (idx_q == 2'd3);
  // The complete word as it stands once the incoming 4th byte lands on top.
  assign word_full = {bus.i_byte, asm_q[23:0]};
  assign count_inc = count_q + CW'(1);

  assign bus.dbg_state = state_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q         <= S_LEN;
      idx_q           <= 2'd0;
      asm_q           <= '0;
      count_q         <= '0;
      n_q             <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q           <= '0;
`endif
      bus.o_ready     <= 1'b1;
      bus.o_we        <= 1'b0;
      bus.o_waddr     <= BASE_ADDR;
      bus.o_wdata     <= '0;
      bus.o_cpu_rst_n <= 1'b0;
      bus.o_done      <= 1'b0;
      bus.o_error     <= 1'b0;
    end else begin
      bus.o_we <= 1'b0;

      if (byte_fire) begin
        idx_q                   <= idx_q + 2'd1;
        asm_q[{idx_q, 3'b000} +: 8] <= bus.i_byte;
      end

      case (state_q)
        S_LEN: begin
          if (last_byte) begin
            if (word_full == '0) begin
              state_q         <= S_DONE;
              bus.o_ready     <= 1'b0;
              bus.o_done      <= 1'b1;
              bus.o_cpu_rst_n <= 1'b1;
            end else if (word_full > 32'(DEPTH)) begin
              state_q     <= S_ERR;
              bus.o_ready <= 1'b0;
              bus.o_error <= 1'b1;
            end else begin
              n_q     <= word_full[CW-1:0];
              count_q <= '0;
              state_q <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (last_byte) begin
            bus.o_we    <= 1'b1;
            bus.o_wdata <= word_full;
            bus.o_waddr <= BASE_ADDR + ADDR_WIDTH'({count_q, 2'b00});
            count_q     <= count_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q       <= sum_q + word_full;
            if (count_inc == n_q) begin
              state_q <= S_CSUM;
            end
`else
            // Done is registered on the same edge as the final write strobe,
            // so the CPU never leaves reset before the last word lands.
            if (count_inc == n_q) begin
              state_q         <= S_DONE;
              bus.o_ready     <= 1'b0;
              bus.o_done      <= 1'b1;
              bus.o_cpu_rst_n <= 1'b1;
            end
`endif
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (last_byte) begin
            bus.o_ready <= 1'b0;
            if (word_full == sum_q) begin
              state_q         <= S_DONE;
              bus.o_done      <= 1'b1;
              bus.o_cpu_rst_n <= 1'b1;
            end else begin
              state_q     <= S_ERR;
              bus.o_error <= 1'b1;
            end
          end
        end
`endif

        S_DONE, S_ERR: begin
          if (bus.i_start) begin
            state_q         <= S_LEN;
            idx_q           <= 2'd0;
            asm_q           <= '0;
            count_q         <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q           <= '0;
`endif
            bus.o_ready     <= 1'b1;
            bus.o_done      <= 1'b0;
            bus.o_error     <= 1'b0;
            bus.o_cpu_rst_n <= 1'b0;
          end
        end

        default: begin
          state_q     <= S_ERR;
          bus.o_ready <= 1'b0;
          bus.o_error <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   cyc;
  int   wr_cnt;
  logic [63:0] exp_q[$];
  int          we_cyc[$];

  imem_loader_if #(.ADDR_WIDTH(32)) bus ();

  imem_loader #(
    .DEPTH(1024),
    .ADDR_WIDTH(32),
    .BASE_ADDR(32'h0)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard: every write strobe is matched against the expected queue
  always @(negedge clk) begin
    if (bus.o_we === 1'b1) begin
      wr_cnt++;
      we_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("spurious_we", 64'(bus.o_we), 64'd0);
      end else begin
        check("wr_addr_data", {bus.o_waddr, bus.o_wdata}, exp_q.pop_front());
      end
    end
  end

  // driver tasks (called at a negedge)
  task automatic apply_reset();
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_start = 1'b0;
    bus.i_byte = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.i_byte = b;
    bus.i_valid = 1'b1;
    while (bus.o_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.o_ready !== 1'b1) check("ready_timeout", 64'(bus.o_ready), 64'd1);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    bus.i_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.i_valid = 1'b0;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic send_csum(input logic [31:0] s);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(s);
`else
    if (s == 32'hffff_ffff) send_word(s); // never true for the images used
`endif
  endtask

  initial begin
    logic [31:0] words [4];
    logic [31:0] s;
    int saved;
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    wr_cnt = 0;
    @(negedge clk);

    // reset state
    apply_reset();
    check("rst_ready", 64'(bus.o_ready), 64'd1);
    check("rst_we", 64'(bus.o_we), 64'd0);
    check("rst_waddr", 64'(bus.o_waddr), 64'd0);
    check("rst_wdata", 64'(bus.o_wdata), 64'd0);
    check("rst_cpu_rst_n", 64'(bus.o_cpu_rst_n), 64'd0);
    check("rst_done_err", {bus.o_done, bus.o_error}, 64'd0);
    check("rst_state", 64'(bus.dbg_state), 64'd0);
    rst_n = 1'b1;

    // N=2 image
    exp_q.push_back({32'h0, 32'h0000_0013});
    exp_q.push_back({32'h4, 32'h0010_0093});
    send_word(32'h2);
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check("cpu_rst_with_last_we", {bus.o_we, bus.o_cpu_rst_n}, 64'b11);
`endif
    send_csum(32'h0010_00A6);
    idle(1);
    check("t1_done", 64'(bus.o_done), 64'd1);
    check("t1_cpu_rst_n", 64'(bus.o_cpu_rst_n), 64'd1);
    check("t1_ready", 64'(bus.o_ready), 64'd0);
    check("t1_drained", 64'(exp_q.size()), 64'd0);
    check("t1_wr_cnt", 64'(wr_cnt), 64'd2);

    // N=0 image
    pulse_start();
    check("t2_rearm", {bus.o_ready, bus.o_done, bus.o_cpu_rst_n}, 64'b100);
    saved = wr_cnt;
    send_word(32'h0);
    check("t2_done", {bus.o_done, bus.o_cpu_rst_n, bus.o_ready}, 64'b110);
    idle(2);
    check("t2_no_write", 64'(wr_cnt), 64'(saved));

    // N=1025 > DEPTH
    pulse_start();
    send_word(32'h0000_0401);
    check("t3_error", {bus.o_error, bus.o_cpu_rst_n, bus.o_ready}, 64'b100);
    bus.i_byte = 8'h55;
    bus.i_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("t3_hold_state", 64'(bus.dbg_state), 64'd3);
    check("t3_no_write", 64'(wr_cnt), 64'(saved));
    pulse_start();
    check("t3_rearm", {bus.o_ready, bus.o_error}, 64'b10);

    // N=4 back-to-back
    words[0] = 32'hA0A1_A2A3;
    words[1] = 32'h1234_5678;
    words[2] = 32'hFFFF_FFFF;
    words[3] = 32'h0000_0001;
    s = 32'h0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({32'(4 * i), words[i]});
      s = s + words[i];
    end
    we_cyc.delete();
    send_word(32'h4);
    for (int i = 0; i < 4; i++) send_word(words[i]);
    send_csum(s);
    idle(1);
    check("t4_we_count", 64'(we_cyc.size()), 64'd4);
    for (int i = 0; i < 3; i++) begin
      if (we_cyc.size() == 4) check("t4_spacing", 64'(we_cyc[i+1] - we_cyc[i]), 64'd4);
    end
    check("t4_done", 64'(bus.o_done), 64'd1);

    // reset mid-load, then fresh N=1 image
    pulse_start();
    send_word(32'h2);
    send_byte(8'h78);
    send_byte(8'h56);
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    @(negedge clk);
    check("t5_rst_state", {bus.dbg_state, bus.o_ready}, 64'b0001);
    rst_n = 1'b1;
    saved = wr_cnt;
    exp_q.push_back({32'h0, 32'hDEAD_BEEF});
    send_word(32'h1);
    send_word(32'hDEAD_BEEF);
    send_csum(32'hDEAD_BEEF);
    idle(2);
    check("t5_one_write", 64'(wr_cnt - saved), 64'd1);
    check("t5_done", 64'(bus.o_done), 64'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // bad checksum
    pulse_start();
    exp_q.push_back({32'h0, 32'h0000_0013});
    exp_q.push_back({32'h4, 32'h0010_0093});
    send_word(32'h2);
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    send_word(32'h0010_00A7);
    idle(1);
    check("t6_bad_csum", {bus.o_error, bus.o_done, bus.o_cpu_rst_n}, 64'b100);
`endif

    check("final_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the read-only instruction memory.
- Receives a little-endian byte stream (from a UART/debug receiver) and assembles it into 32-bit instruction words.
- Issues one write per word into the instruction memory write port, starting at BASE_ADDR.
- Holds the CPU in reset until the full program image is loaded.

Parameters:
- DEPTH, 1024, instruction memory depth in words; the maximum loadable word count.
- ADDR_WIDTH, 32, width of the byte address driven to imem; the `ADDR_WIDTH macro value.
- BASE_ADDR, 0, byte address of the first word written; must be 4-byte aligned.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_start  in  1  re-arms the loader from S_DONE or S_ERR; ignored in other states.
- i_byte  in  8  stream data byte.
- i_valid  in  1  i_byte is valid.
- o_ready  out  1  loader can accept a byte; a byte transfers when i_valid && o_ready.
- o_we  out  1  imem write strobe, one-cycle pulse per word.
- o_waddr  out  ADDR_WIDTH  imem byte address, word aligned.
- o_wdata  out  32 (`INST_WIDTH)  assembled instruction word.
- o_cpu_rst_n  out  1  CPU reset, low until the load completes successfully.
- o_done  out  1  load completed successfully.
- o_error  out  1  load aborted.

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - State goes to S_LEN; byte index, word counter and assembly register are cleared.
  - Outputs: o_ready=1, o_we=0, o_waddr=BASE_ADDR, o_wdata=0, o_cpu_rst_n=0, o_done=0, o_error=0.
  - A reset mid-load discards any partial word and in-progress count. Words already written stay in imem.
- Byte assembly:
  - A 2-bit index counts bytes within a word.
  - Byte k (0..3) goes to bits [8k+7:8k]; byte 0 is the LSB.
  - The index wraps 3→0 on every 4th accepted byte.
- S_LEN:
  - o_ready=1; accepts 4 bytes forming the word count N.
  - On the 4th byte:
    - N==0 → S_DONE.
    - N>DEPTH → S_ERR.
    - Otherwise latch N, clear the word counter, and go to S_DATA.
- S_DATA:
  - o_ready=1.
  - On the 4th byte of each word, on the next cycle: o_we=1 for exactly one cycle, o_wdata = the assembled word, o_waddr = BASE_ADDR + 4*count. count then increments.
  - Byte acceptance continues in the same cycle o_we is high; there are no bubbles.
  - When count reaches N, after the final write: go to S_CSUM if the feature is enabled, otherwise S_DONE.
- S_DONE:
  - o_ready=0, o_done=1, o_cpu_rst_n=1.
  - o_cpu_rst_n rises in the same cycle as the last o_we, so the CPU leaves reset no earlier than the last write.
- S_ERR:
  - o_ready=0, o_error=1, o_cpu_rst_n=0.
- Leaving S_DONE/S_ERR:
  - i_start=1 → S_LEN; o_done, o_error and o_cpu_rst_n are all cleared on the next cycle.
  - i_start is ignored in S_LEN, S_DATA and S_CSUM.
- i_valid with o_ready=0: the byte is not consumed; no state change.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. This cannot occur when N≤DEPTH with BASE_ADDR chosen sensibly.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN
- Defined:
  - A 32-bit running sum (mod 2^32) of all data words written accumulates during S_DATA. It is cleared on entering S_LEN.
  - After N words, S_CSUM accepts 4 more bytes (little-endian).
  - Match → S_DONE; mismatch → S_ERR.
  - With N==0 the loader still goes directly to S_DONE; no checksum bytes are expected.
- Undefined:
  - S_CSUM and the accumulator are absent.
  - The loader goes S_DATA → S_DONE after the N-th word.

Test Plan:
- Reset, then stream 02 00 00 00, 13 00 00 00, 93 00 10 00 →
  - o_we pulses twice: (0x0, 0x00000013) and (0x4, 0x00100093).
  - After the last write: o_done=1, o_cpu_rst_n=1, o_ready=0.
- Stream 00 00 00 00 → S_DONE immediately; no o_we pulse.
- With DEPTH=1024, stream 01 04 00 00 (N=1025) → o_error=1, o_cpu_rst_n=0, no writes.
  - Then pulse i_start → o_ready=1, o_error=0.
- Hold i_valid high with back-to-back bytes for N=4 →
  - Four o_we pulses exactly 4 cycles apart.
  - Addresses 0x0, 0x4, 0x8, 0xC.
- Assert i_rst_n=0 after 6 bytes of a load, then stream a fresh N=1 image →
  - A single write at BASE_ADDR with the new word; no write from the aborted partial word.
- IMEM_LOADER_CHECKSUM_EN: N=2, words 0x00000013 and 0x00100093, then checksum A6 00 10 00 → o_done=1.
  - With checksum A7 00 10 00 → o_error=1, o_cpu_rst_n=0.
